// File: rtl/cpu_sequencer_if.sv
// Handshake and control bus between the sequencer and its fetch/decode/execute neighbours.
// Master drives the instruction-side inputs; slave (the sequencer) drives pc and controls.
// Purely structural, no storage.
interface cpu_sequencer_if;
  logic        start;
  logic [31:0] ins;
  logic        zero;
  logic [31:0] imm;
  logic [25:0] jTarget;

  logic [31:0] pc;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        Mem2Reg;
  logic [2:0]  op;
  logic [2:0]  state;
  logic [31:0] insn_count;
  logic        halted;
  logic        illegal;

  modport master (
    output start, ins, zero, imm, jTarget,
    input  pc, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
    input  op, state, insn_count, halted, illegal
  );

  modport slave (
    input  start, ins, zero, imm, jTarget,
    output pc, RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
    output op, state, insn_count, halted, illegal
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with pc update and retire counting.
// Controls are registered: they change on the edge that enters a state, 3 to 5 cycles per instruction.
// No backpressure; start is sampled only in IDLE, HALT persists until rst.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'd128,
  parameter logic [31:0] MAX_INSNS = 32'd11
) (
  input logic          clk,
  input logic          rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } cls_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ir_q, ir_d;
  logic        ill_q, ill_d;

  logic        regdst_q, regdst_d;
  logic        regwrite_q, regwrite_d;
  logic        alusrc_q, alusrc_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        mem2reg_q, mem2reg_d;
  logic [2:0]  op_q, op_d;
  logic        halted_q, halted_d;

  cls_t        cls;
  logic [2:0]  dec_op;
  logic [31:0] pc_plus4;
  logic [31:0] cnt_inc;
  logic [31:0] pc_next;
  logic        retire;
  logic        unused_ir_bits;

  // IR captures the fetched word on the FETCH exit edge; decoding IR's next value lets
  // the controls be valid in the very first DECODE cycle.
  assign ir_d           = (state_q == S_FETCH) ? bus.ins : ir_q;
  assign unused_ir_bits = ^ir_d[25:6];

  assign pc_plus4 = pc_q + 32'd4;
  assign cnt_inc  = cnt_q + 32'd1;

  // Classify the instruction and pick its ALU operation.
  always_comb begin
    cls    = C_ILL;
    dec_op = 3'b000;
    case (ir_d[31:26])
      6'h00: begin
        case (ir_d[5:0])
          6'h20: begin cls = C_R; dec_op = 3'b010; end
          6'h22: begin cls = C_R; dec_op = 3'b110; end
          6'h24: begin cls = C_R; dec_op = 3'b000; end
          6'h25: begin cls = C_R; dec_op = 3'b001; end
          6'h2A: begin cls = C_R; dec_op = 3'b111; end
          default: cls = C_ILL;
        endcase
      end
      6'h08:   begin cls = C_ADDI; dec_op = 3'b010; end
      6'h23:   begin cls = C_LW;   dec_op = 3'b010; end
      6'h2B:   begin cls = C_SW;   dec_op = 3'b010; end
      6'h04:   begin cls = C_BEQ;  dec_op = 3'b110; end
      6'h02:   begin cls = C_J;    dec_op = 3'b000; end
      default: cls = C_ILL;
    endcase
  end

  // Next state, pc and retire bookkeeping; a retire happens on the last state of each path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    retire  = 1'b0;
    pc_next = pc_plus4;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls == C_ILL) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_R, C_ADDI: state_d = S_WB;
          C_LW, C_SW:  state_d = S_MEM;
          C_BEQ: begin
            retire = 1'b1;
            if (bus.zero) pc_next = pc_plus4 + {bus.imm[29:0], 2'b00};
          end
          C_J: begin
            retire  = 1'b1;
            pc_next = {pc_plus4[31:28], bus.jTarget, 2'b00};
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (cls == C_LW) state_d = S_WB;
        else             retire  = 1'b1;
      end
      S_WB:   retire  = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (retire) begin
      pc_d    = pc_next;
      cnt_d   = cnt_inc;
      state_d = ((MAX_INSNS != 32'd0) && (cnt_inc == MAX_INSNS)) ? S_HALT : S_FETCH;
    end
  end

  // Controls for the state being entered, so the registered outputs line up with state.
  always_comb begin
    regdst_d   = 1'b0;
    regwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    mem2reg_d  = 1'b0;
    op_d       = 3'b000;
    halted_d   = (state_d == S_HALT);
    if ((state_d == S_DECODE || state_d == S_EXEC || state_d == S_MEM || state_d == S_WB)
        && (cls != C_ILL)) begin
      regdst_d   = (cls == C_R);
      alusrc_d   = (cls == C_ADDI) || (cls == C_LW) || (cls == C_SW);
      mem2reg_d  = (cls == C_LW);
      op_d       = dec_op;
      regwrite_d = (state_d == S_WB);
      memread_d  = (state_d == S_MEM) && (cls == C_LW);
      memwrite_d = (state_d == S_MEM) && (cls == C_SW);
    end
  end

  // Single state register for the FSM and all of its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= 32'd0;
      ir_q       <= 32'd0;
      ill_q      <= 1'b0;
      regdst_q   <= 1'b0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      mem2reg_q  <= 1'b0;
      op_q       <= 3'b000;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ill_q      <= ill_d;
      regdst_q   <= regdst_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      mem2reg_q  <= mem2reg_d;
      op_q       <= op_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.insn_count = cnt_q;
  assign bus.state      = state_q;
  assign bus.illegal    = ill_q;
  assign bus.halted     = halted_q;
  assign bus.RegDst     = regdst_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.ALUSrc     = alusrc_q;
  assign bus.MemRead    = memread_q;
  assign bus.MemWrite   = memwrite_q;
  assign bus.Mem2Reg    = mem2reg_q;
  assign bus.op         = op_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: one unlimited instance driven by directed and random instructions,
// plus a MAX_INSNS=2 instance running in lockstep to exercise the retire limit.
// Expected state paths, controls and pc come from an instruction-level model.
module tb_cpu_sequencer;

  localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r;
  logic [31:0] ins_r;
  logic        zero_r;
  logic [31:0] imm_r;
  logic [25:0] jt_r;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  cpu_sequencer_if bus_m ();
  cpu_sequencer_if bus_l ();

  assign bus_m.start   = start_r;
  assign bus_m.ins     = ins_r;
  assign bus_m.zero    = zero_r;
  assign bus_m.imm     = imm_r;
  assign bus_m.jTarget = jt_r;
  assign bus_l.start   = start_r;
  assign bus_l.ins     = ins_r;
  assign bus_l.zero    = zero_r;
  assign bus_l.imm     = imm_r;
  assign bus_l.jTarget = jt_r;

  cpu_sequencer #(.RESET_PC(32'd128), .MAX_INSNS(32'd0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_m)
  );
  cpu_sequencer #(.RESET_PC(32'd128), .MAX_INSNS(32'd2)) u_lim (
    .clk(clk), .rst(rst), .bus(bus_l)
  );

  logic [8:0] ctl_m, ctl_l;
  assign ctl_m = {bus_m.RegDst, bus_m.RegWrite, bus_m.ALUSrc, bus_m.MemRead,
                  bus_m.MemWrite, bus_m.Mem2Reg, bus_m.op};
  assign ctl_l = {bus_l.RegDst, bus_l.RegWrite, bus_l.ALUSrc, bus_l.MemRead,
                  bus_l.MemWrite, bus_l.Mem2Reg, bus_l.op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int classify(input logic [31:0] w);
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return K_R;
          default: return K_ILL;
        endcase
      end
      6'h08: return K_ADDI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] w, input int k);
    if (k == K_R) begin
      case (w[5:0])
        6'h20: return 3'b010;
        6'h22: return 3'b110;
        6'h24: return 3'b000;
        6'h25: return 3'b001;
        default: return 3'b111;
      endcase
    end
    if (k == K_ADDI || k == K_LW || k == K_SW) return 3'b010;
    if (k == K_BEQ) return 3'b110;
    return 3'b000;
  endfunction

  // Control vector expected while the instruction sits in state code st.
  function automatic logic [8:0] exp_ctl(input int k, input logic [31:0] w, input int st);
    logic rd, rw, as, mr, mw, m2r;
    if (k == K_ILL) return 9'd0;
    rd  = (k == K_R);
    rw  = (st == 5);
    as  = (k == K_ADDI || k == K_LW || k == K_SW);
    mr  = (st == 4) && (k == K_LW);
    mw  = (st == 4) && (k == K_SW);
    m2r = (k == K_LW);
    return {rd, rw, as, mr, mw, m2r, alu_of(w, k)};
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    start_r = 1'($urandom_range(0, 1));
    step();
    step();
    rst     = 1'b0;
    start_r = 1'b0;
    m_pc    = 32'd128;
    m_cnt   = 32'd0;
  endtask

  task automatic do_start();
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    chk("start_state", 32'(bus_m.state), 32'd1);
  endtask

  // Runs one instruction on the main instance from FETCH, checking each cycle.
  task automatic run_insn(input logic [31:0] w, input logic [31:0] imm, input logic [25:0] jt,
                          input logic z);
    int          k;
    int          path[$];
    logic [31:0] nxt;
    k = classify(w);
    path = {2};
    if (k != K_ILL) path.push_back(3);
    if (k == K_R || k == K_ADDI) path.push_back(5);
    if (k == K_LW) begin path.push_back(4); path.push_back(5); end
    if (k == K_SW) path.push_back(4);
    chk("fetch_state", 32'(bus_m.state), 32'd1);
    ins_r = w;
    imm_r = imm;
    jt_r  = jt;
    foreach (path[i]) begin
      step();
      chk($sformatf("state_s%0d", path[i]), 32'(bus_m.state), 32'(path[i]));
      chk($sformatf("ctl_s%0d", path[i]), 32'(ctl_m), 32'(exp_ctl(k, w, path[i])));
      ins_r   = $urandom;
      zero_r  = (path[i] == 3) ? z : 1'($urandom_range(0, 1));
      start_r = 1'($urandom_range(0, 1));
    end
    step();
    start_r = 1'b0;
    if (k == K_ILL) begin
      chk("ill_state", 32'(bus_m.state), 32'd6);
      chk("ill_flag", 32'(bus_m.illegal), 32'd1);
      chk("ill_halted", 32'(bus_m.halted), 32'd1);
      chk("ill_cnt", bus_m.insn_count, m_cnt);
      chk("ill_pc", bus_m.pc, m_pc);
    end else begin
      if (k == K_BEQ && z) nxt = m_pc + 32'd4 + imm * 32'd4;
      else if (k == K_J)   nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jt) << 2);
      else                 nxt = m_pc + 32'd4;
      m_pc  = nxt;
      m_cnt = m_cnt + 32'd1;
      chk("ret_state", 32'(bus_m.state), 32'd1);
      chk("ret_pc", bus_m.pc, m_pc);
      chk("ret_cnt", bus_m.insn_count, m_cnt);
      chk("ret_ctl", 32'(ctl_m), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [5:0] fn;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          default: fn = 6'h2A;
        endcase
        return {6'h00, r[25:6], fn};
      end
      1: return {6'h08, r[25:0]};
      2: return {6'h23, r[25:0]};
      3: return {6'h2B, r[25:0]};
      4: return {6'h04, r[25:0]};
      default: return {6'h02, r[25:0]};
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    start_r = 1'b0;
    ins_r   = 32'd0;
    zero_r  = 1'b0;
    imm_r   = 32'd0;
    jt_r    = 26'd0;
    do_reset();

    chk("rst_state", 32'(bus_m.state), 32'd0);
    chk("rst_pc", bus_m.pc, 32'd128);
    chk("rst_cnt", bus_m.insn_count, 32'd0);
    chk("rst_ctl", 32'(ctl_m), 32'd0);
    chk("rst_halted", 32'(bus_m.halted), 32'd0);
    chk("rst_illegal", 32'(bus_m.illegal), 32'd0);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_hold", 32'(bus_m.state), 32'd0);
    end
    do_start();

    run_insn(32'h20A5_0001, 32'd1, 26'd0, 1'b0);
    chk("lim_state1", 32'(bus_l.state), 32'd1);
    chk("lim_cnt1", bus_l.insn_count, 32'd1);
    run_insn(32'h20A5_0002, 32'd2, 26'd0, 1'b0);
    chk("lim_halt", 32'(bus_l.state), 32'd6);
    chk("lim_halted", 32'(bus_l.halted), 32'd1);
    chk("lim_cnt2", bus_l.insn_count, 32'd2);
    chk("lim_pc", bus_l.pc, 32'd136);
    chk("lim_ctl", 32'(ctl_l), 32'd0);

    run_insn(32'h0085_3020, 32'd0, 26'd0, 1'b0);
    run_insn(32'h8C88_0004, 32'd4, 26'd0, 1'b0);
    run_insn(32'h1000_FFFE, 32'hFFFF_FFFE, 26'd0, 1'b1);
    run_insn(32'h1000_FFFE, 32'hFFFF_FFFE, 26'd0, 1'b0);
    run_insn(32'hAC88_0008, 32'd8, 26'd0, 1'b0);
    run_insn(32'h1000_0000, (32'h1000_0080 - m_pc - 32'd4) >> 2, 26'd0, 1'b1);
    chk("pc_far", bus_m.pc, 32'h1000_0080);
    run_insn(32'h0800_0020, 32'd0, 26'h000_0020, 1'b0);
    chk("pc_jump", bus_m.pc, 32'h1000_0080);

    for (int i = 0; i < 40; i++)
      run_insn(rand_legal(), $urandom, 26'($urandom), 1'($urandom_range(0, 1)));

    chk("lim_still_halt", 32'(bus_l.state), 32'd6);
    chk("lim_still_cnt", bus_l.insn_count, 32'd2);
    chk("lim_still_pc", bus_l.pc, 32'd136);
    chk("lim_no_illegal", 32'(bus_l.illegal), 32'd0);

    // Reset lands while a load is in EXEC.
    ins_r = 32'h8C88_0004;
    step();
    chk("rl_dec", 32'(bus_m.state), 32'd2);
    step();
    chk("rl_exec", 32'(bus_m.state), 32'd3);
    rst = 1'b1;
    start_r = 1'b1;
    step();
    chk("rl_state", 32'(bus_m.state), 32'd0);
    chk("rl_pc", bus_m.pc, 32'd128);
    chk("rl_cnt", bus_m.insn_count, 32'd0);
    chk("rl_ctl", 32'(ctl_m), 32'd0);
    rst = 1'b0;
    start_r = 1'b0;
    m_pc  = 32'd128;
    m_cnt = 32'd0;
    step();
    chk("rl_idle", 32'(bus_m.state), 32'd0);
    chk("rl_ctl2", 32'(ctl_m), 32'd0);

    // Unsupported funct, then unsupported opcode after a fresh reset.
    do_start();
    run_insn(32'h20A5_0003, 32'd3, 26'd0, 1'b0);
    run_insn(32'h0085_3021, 32'd0, 26'd0, 1'b0);
    do_reset();
    chk("rst_clr_illegal", 32'(bus_m.illegal), 32'd0);
    do_start();
    run_insn(32'hFC00_0000, 32'd0, 26'd0, 1'b0);
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    step();
    chk("halt_hold_state", 32'(bus_m.state), 32'd6);
    chk("halt_hold_cnt", bus_m.insn_count, 32'd0);
    chk("halt_hold_pc", bus_m.pc, 32'd128);
    chk("halt_hold_ill", 32'(bus_m.illegal), 32'd1);
    chk("halt_hold_ctl", 32'(ctl_m), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
